nios_mult_pipe: RTL and testbench

Parametrised, stallable, pipelined integer multiplier for the Nios-class CPU execute/memory stages. It replaces the fixed three-cell 16x16 partial-product arrangement with a generic two-limb decomposition of any even DATA_W. It tracks valid/flush through the pipe and returns either the low or the high word of the product in all four signedness modes (MUL, MULH, MULHSU, MULHU).

---
 rtl/nios_mult_pkg.sv | 17 +
 rtl/nios_mult_limb.sv | 29 ++
 rtl/nios_mult_pipe.sv | 170 +++++++++++++++++
 tb/tb_nios_mult_pipe.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/nios_mult_pkg.sv
// Shared types for the Nios multiplier pipe: product-word select modes.
package nios_mult_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MUL_LO  = 2'd0,
    MUL_HSS = 2'd1,
    MUL_HSU = 2'd2,
    MUL_HUU = 2'd3
  } mult_mode_e;

  function automatic logic mode_is_high(input mult_mode_e m);
    return m != MUL_LO;
  endfunction

endpackage

// File: rtl/nios_mult_limb.sv
// Registered L x L unsigned multiply cell with enable and async clear;
// kept as its own module so each instance maps onto one DSP block.
module nios_mult_limb #(
  parameter int L = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           i_en,
  input  logic [L-1:0]   i_a,
  input  logic [L-1:0]   i_b,
  output logic [2*L-1:0] o_p
);

  logic [2*L-1:0] r_p;
  logic [2*L-1:0] w_prod;

  assign w_prod = {{L{1'b0}}, i_a} * {{L{1'b0}}, i_b};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p <= '0;
    end else if (i_en) begin
      r_p <= w_prod;
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/nios_mult_pipe.sv
// Stallable two-limb pipelined multiplier returning the low or high product word.
// High-word modes are built only when NIOS_MULT_HIGH_EN is defined; otherwise they return 0.
module nios_mult_pipe
  import nios_mult_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [MODE_W-1:0] mode,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              out_valid,
  output logic [DATA_W-1:0] result
);

  localparam int L = DATA_W / 2;

  // Operand capture stage feeding the limb multipliers
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  mult_mode_e        r_mode0;
  logic              r_v0;

  // Product stage (limb registers live inside nios_mult_limb)
  mult_mode_e        r_mode1;
  logic              r_v1;

  logic [DATA_W-1:0] w_pll;
  logic [DATA_W-1:0] w_plh;
  logic [DATA_W-1:0] w_phl;
  logic [DATA_W:0]   w_mid;
  logic [2*DATA_W-1:0] w_full;
  logic [DATA_W-1:0] w_low;
  logic [DATA_W-1:0] w_high;
  logic [DATA_W-1:0] w_res;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_mode0 <= MUL_LO;
      r_mode1 <= MUL_LO;
      r_v0    <= 1'b0;
      r_v1    <= 1'b0;
    end else begin
      if (en) begin
        r_a     <= src1;
        r_b     <= src2;
        r_mode0 <= mult_mode_e'(mode);
        r_mode1 <= r_mode0;
      end
      // Flush kills valid bits even while stalled; data is left alone
      if (flush) begin
        r_v0 <= 1'b0;
        r_v1 <= 1'b0;
      end else if (en) begin
        r_v0 <= in_valid;
        r_v1 <= r_v0;
      end
    end
  end

  nios_mult_limb #(.L(L)) u_limb_ll (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (en),
    .i_a     (r_a[L-1:0]),
    .i_b     (r_b[L-1:0]),
    .o_p     (w_pll)
  );

  nios_mult_limb #(.L(L)) u_limb_lh (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (en),
    .i_a     (r_a[L-1:0]),
    .i_b     (r_b[DATA_W-1:L]),
    .o_p     (w_plh)
  );

  nios_mult_limb #(.L(L)) u_limb_hl (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (en),
    .i_a     (r_a[DATA_W-1:L]),
    .i_b     (r_b[L-1:0]),
    .o_p     (w_phl)
  );

  assign w_mid = {1'b0, w_plh} + {1'b0, w_phl};

`ifdef NIOS_MULT_HIGH_EN
  logic [DATA_W-1:0] w_phh;
  logic [DATA_W-1:0] w_c_a;
  logic [DATA_W-1:0] w_c_b;
  logic [DATA_W-1:0] r_c;

  nios_mult_limb #(.L(L)) u_limb_hh (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (en),
    .i_a     (r_a[DATA_W-1:L]),
    .i_b     (r_b[DATA_W-1:L]),
    .o_p     (w_phh)
  );

  // Signed operands are treated as unsigned in the limbs; c undoes the
  // 2^DATA_W weight of each negative operand's sign bit in the high word.
  assign w_c_a = ((r_mode0 == MUL_HSS || r_mode0 == MUL_HSU) && r_a[DATA_W-1]) ? r_b : '0;
  assign w_c_b = ((r_mode0 == MUL_HSS) && r_b[DATA_W-1]) ? r_a : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_c <= '0;
    end else if (en) begin
      r_c <= w_c_a + w_c_b;
    end
  end

  assign w_full = {{DATA_W{1'b0}}, w_pll}
                + ({{(DATA_W-1){1'b0}}, w_mid} << L)
                + {w_phh, {DATA_W{1'b0}}};
  assign w_high = w_full[2*DATA_W-1:DATA_W] - r_c;
`else
  logic w_unused_high;

  assign w_full = {{DATA_W{1'b0}}, w_pll}
                + ({{(DATA_W-1){1'b0}}, w_mid} << L);
  assign w_unused_high = ^w_full[2*DATA_W-1:DATA_W];
  assign w_high = '0;
`endif

  assign w_low = w_full[DATA_W-1:0];
  assign w_res = mode_is_high(r_mode1) ? w_high : w_low;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              r_v2;
      logic [DATA_W-1:0] r_res;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_v2  <= 1'b0;
          r_res <= '0;
        end else begin
          if (en) begin
            r_res <= w_res;
          end
          if (flush) begin
            r_v2 <= 1'b0;
          end else if (en) begin
            r_v2 <= r_v1;
          end
        end
      end

      assign out_valid = r_v2;
      assign result    = r_res;
    end else begin : g_out_comb
      assign out_valid = r_v1;
      assign result    = w_res;
    end
  endgenerate

endmodule

// File: tb/tb_nios_mult_pipe.sv
// Self-checking bench: DATA_W=32/OUT_REG=0 and DATA_W=16/OUT_REG=1 instances
// share one stimulus stream and are compared every cycle against a wide-arithmetic model.
module tb_nios_mult_pipe;
  import nios_mult_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;

  logic        ov32;
  logic [31:0] res32;
  logic        ov16;
  logic [15:0] res16;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

`ifdef NIOS_MULT_HIGH_EN
  localparam logic [31:0] EXP_HU_1616 = 32'h0000_0001;
  localparam logic [31:0] EXP_HSS_FF  = 32'h0000_0000;
  localparam logic [31:0] EXP_HUU_FF  = 32'hFFFF_FFFE;
  localparam logic [31:0] EXP_HSU_FF  = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP_HU_8002 = 32'h0000_0001;
`else
  localparam logic [31:0] EXP_HU_1616 = 32'h0;
  localparam logic [31:0] EXP_HSS_FF  = 32'h0;
  localparam logic [31:0] EXP_HUU_FF  = 32'h0;
  localparam logic [31:0] EXP_HSU_FF  = 32'h0;
  localparam logic [31:0] EXP_HU_8002 = 32'h0;
`endif

  always #5 clk = ~clk;

  nios_mult_pipe #(.DATA_W(32), .OUT_REG(0)) dut32 (
    .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .in_valid(in_valid),
    .mode(mode), .src1(src1), .src2(src2), .out_valid(ov32), .result(res32)
  );

  nios_mult_pipe #(.DATA_W(16), .OUT_REG(1)) dut16 (
    .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .in_valid(in_valid),
    .mode(mode), .src1(src1[15:0]), .src2(src2[15:0]), .out_valid(ov16), .result(res16)
  );

  // Expected product word from plain 128-bit arithmetic on sign/zero-extended operands
  function automatic logic [31:0] ref_mul(input logic [1:0] m, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
    logic [127:0] mask, ea, eb, p;
    mask = (128'd1 << w) - 128'd1;
    ea = {96'd0, a} & mask;
    eb = {96'd0, b} & mask;
    if ((m == 2'd1 || m == 2'd2) && ea[w-1]) ea = ea | ~mask;
    if (m == 2'd1 && eb[w-1]) eb = eb | ~mask;
    p = ea * eb;
    if (m == 2'd0) begin
      p = p & mask;
      return p[31:0];
    end
`ifdef NIOS_MULT_HIGH_EN
    p = (p >> w) & mask;
    return p[31:0];
`else
    return 32'h0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural pipe model: each slot holds the product the output will show after that many advances
  logic        m32_v[2];
  logic [31:0] m32_d[2];
  logic        m16_v[3];
  logic [31:0] m16_d[3];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin m32_v[i] = 1'b0; m32_d[i] = '0; end
      for (int i = 0; i < 3; i++) begin m16_v[i] = 1'b0; m16_d[i] = '0; end
    end else begin
      if (en) begin
        m32_v[1] = m32_v[0];
        m32_d[1] = m32_d[0];
        m32_v[0] = in_valid;
        m32_d[0] = ref_mul(mode, src1, src2, 32);
        for (int i = 2; i > 0; i--) begin
          m16_v[i] = m16_v[i-1];
          m16_d[i] = m16_d[i-1];
        end
        m16_v[0] = in_valid;
        m16_d[0] = ref_mul(mode, src1, src2, 16);
      end
      if (flush) begin
        for (int i = 0; i < 2; i++) m32_v[i] = 1'b0;
        for (int i = 0; i < 3; i++) m16_v[i] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started && reset_n) begin
      chk("v32", {31'd0, ov32}, {31'd0, m32_v[1]});
      if (m32_v[1]) chk("r32", res32, m32_d[1]);
      chk("v16", {31'd0, ov16}, {31'd0, m16_v[2]});
      if (m16_v[2]) chk("r16", {16'd0, res16}, m16_d[2]);
    end
  end

  task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] a,
                       input logic [31:0] b, input logic e, input logic f);
    @(negedge clk);
    #1;
    in_valid = v; mode = m; src1 = a; src2 = b; en = e; flush = f;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
  endtask

  // Single op into an empty pipe: not valid after one edge, valid with the literal after two
  task automatic one_op(input string nm, input logic [1:0] m, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    drive(1'b1, m, a, b, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk({nm, "_early"}, {31'd0, ov32}, 32'd0);
    @(negedge clk);
    chk({nm, "_v"}, {31'd0, ov32}, 32'd1);
    chk(nm, res32, exp);
    idle(3);
  endtask

  initial begin
    // Pin the model against hand-computed products
    chk("pin_mul",   ref_mul(2'd0, 32'h0001_0000, 32'h0001_0000, 32), 32'h0);
    chk("pin_hu",    ref_mul(2'd3, 32'h0001_0000, 32'h0001_0000, 32), EXP_HU_1616);
    chk("pin_hss",   ref_mul(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32), EXP_HSS_FF);
    chk("pin_huu",   ref_mul(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32), EXP_HUU_FF);
    chk("pin_hsu",   ref_mul(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32), EXP_HSU_FF);
    chk("pin_lo_ff", ref_mul(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32), 32'h1);
    chk("pin_16lo",  ref_mul(2'd0, 32'h0000_1234, 32'h0000_0010, 16), 32'h0000_2340);

    repeat (3) @(negedge clk);
    chk("rst_v32", {31'd0, ov32}, 32'd0);
    chk("rst_r32", res32, 32'd0);
    chk("rst_v16", {31'd0, ov16}, 32'd0);
    chk("rst_r16", {16'd0, res16}, 32'd0);
    #1 reset_n = 1'b1;
    started = 1'b1;
    idle(2);

    one_op("mul_1616",  2'd0, 32'h0001_0000, 32'h0001_0000, 32'h0);
    one_op("huu_1616",  2'd3, 32'h0001_0000, 32'h0001_0000, EXP_HU_1616);
    one_op("hss_ff",    2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, EXP_HSS_FF);
    one_op("huu_ff",    2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, EXP_HUU_FF);
    one_op("hsu_ff",    2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, EXP_HSU_FF);
    one_op("mul_ff",    2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
    one_op("huu_8002",  2'd3, 32'h8000_0000, 32'h0000_0002, EXP_HU_8002);

    // Stream of 8 with a 3-cycle stall in the middle
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        for (int k = 0; k < 3; k++)
          drive(1'b1, 2'd3, 32'hDEAD_0000 + k, 32'h0BAD_0000, 1'b0, 1'b0);
      end
      drive(1'b1, 2'(i), 32'h1234_5678 * (i + 1), 32'h8765_4321 - i, 1'b1, 1'b0);
    end
    idle(5);

    // Flush while two ops are in flight and stalled
    drive(1'b1, 2'd0, 32'h0000_0007, 32'h0000_0009, 1'b1, 1'b0);
    drive(1'b1, 2'd1, 32'h8000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("flush_v32", {31'd0, ov32}, 32'd0);
    drive(1'b1, 2'd0, 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("post_flush_v", {31'd0, ov32}, 32'd1);
    chk("post_flush_r", res32, 32'd15);
    idle(4);

    // Reset pulse with a full pipe
    for (int i = 0; i < 4; i++)
      drive(1'b1, 2'd0, 32'h0000_0101 + i, 32'h0000_0033, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_v32", {31'd0, ov32}, 32'd0);
    chk("midrst_r32", res32, 32'd0);
    chk("midrst_v16", {31'd0, ov16}, 32'd0);
    chk("midrst_r16", {16'd0, res16}, 32'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    idle(1);
    one_op("recover", 2'd0, 32'h0000_00FF, 32'h0000_0101, 32'h0000_FFFF);

    // Random mix: en mostly high, occasional flush, all modes
    for (int i = 0; i < 200; i++)
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom,
            $urandom_range(0, 4) != 0, $urandom_range(0, 19) == 0);
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
